jtimegen: RTL

Parametrised CPU timing generator: one block produces the four-phase clock set (`wclk`, `wclkd`, `wclke`, `wclks`) and an N-step one-hot stepper advanced by that clock set. It adds run/halt, single-step, early step-reset and phase stretching. It sits between the board clock and the control section, and drives the enable/set gating for every register and the instruction decoder.

---
 rtl/jtime_pkg.sv | 34 +++
 rtl/jphase_gen.sv | 63 ++++++
 rtl/jtimegen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jtime_pkg.sv
// Shared types and constants for the jtimegen timing generator.
package jtime_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SINGLE = 2'd2
    } state_e;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam int STEPS_MIN     = 2;
    localparam int STEPS_MAX     = 32;
    localparam int PHASE_LEN_MIN = 1;
    localparam int PHASE_LEN_MAX = 16;
    localparam int PRESC_W       = 4;

    // Returns {wclk, wclkd, wclke, wclks} for a phase.
    function automatic logic [3:0] phase_decode(input logic [1:0] ph);
        logic [3:0] clocks;
        case (ph)
            PH0:     clocks = 4'b1010;
            PH1:     clocks = 4'b1111;
            PH2:     clocks = 4'b0110;
            PH3:     clocks = 4'b0000;
            default: clocks = 4'b0000;
        endcase
        return clocks;
    endfunction

endpackage

// File: rtl/jphase_gen.sv
// Phase counter with PHASE_LEN prescaler, registered four-clock decode and
// a step-boundary strobe for the stepper.
module jphase_gen
    import jtime_pkg::*;
#(
    parameter int PHASE_LEN = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic go,
    output logic wclk,
    output logic wclkd,
    output logic wclke,
    output logic wclks,
    output logic boundary
);

    logic [1:0]         phase_r;
    logic [1:0]         phase_next_s;
    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_next_s;
    logic               last_s;

    assign last_s   = (presc_r == PRESC_W'(PHASE_LEN - 1));
    assign boundary = active & last_s & (phase_r == PH3);

    // Next phase/prescaler; both restart at zero whenever the block is or becomes idle.
    always_comb begin
        phase_next_s = PH0;
        presc_next_s = PRESC_W'(0);
        if (active && go) begin
            if (last_s) begin
                phase_next_s = phase_r + 2'd1;
                presc_next_s = PRESC_W'(0);
            end else begin
                phase_next_s = phase_r;
                presc_next_s = presc_r + PRESC_W'(1);
            end
        end else begin
            phase_next_s = PH0;
            presc_next_s = PRESC_W'(0);
        end
    end

    // Clocks are decoded from the next phase so they line up with the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r                    <= PH0;
            presc_r                    <= PRESC_W'(0);
            {wclk, wclkd, wclke, wclks} <= 4'b0000;
        end else begin
            phase_r <= phase_next_s;
            presc_r <= presc_next_s;
            if (go) begin
                {wclk, wclkd, wclke, wclks} <= phase_decode(phase_next_s);
            end else begin
                {wclk, wclkd, wclke, wclks} <= 4'b0000;
            end
        end
    end

endmodule

// File: rtl/jtimegen.sv
// CPU timing generator: run/halt/single-step FSM driving a four-phase clock
// set and a one-hot machine-step ring with early step reset.
module jtimegen
    import jtime_pkg::*;
#(
    parameter int STEPS     = 6,
    parameter int PHASE_LEN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     step,
    input  logic                     step_rst,
    output logic                     wclk,
    output logic                     wclkd,
    output logic                     wclke,
    output logic                     wclks,
    output logic [0:STEPS-1]         bos,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     cycle_done,
    output logic                     halted
);

    localparam int IDX_W = $clog2(STEPS);
    localparam logic [0:STEPS-1] BOS_INIT = {1'b1, {(STEPS-1){1'b0}}};

    generate
        if (STEPS < STEPS_MIN || STEPS > STEPS_MAX ||
            PHASE_LEN < PHASE_LEN_MIN || PHASE_LEN > PHASE_LEN_MAX) begin : g_param_err
            $error("jtimegen: STEPS or PHASE_LEN outside legal range");
        end
    endgenerate

    logic [1:0] rst_sync_r;
    logic       rst_n_s;
    state_e     state_r;
    state_e     state_next_s;
    logic       flag_r;
    logic       boundary_s;
    logic       active_s;
    logic       go_s;
    logic       wrap_s;

    // Assertion is immediate; release waits two clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s  = rst_sync_r[1];
    assign active_s = (state_r != ST_IDLE);
    assign go_s     = (state_next_s != ST_IDLE);
    assign wrap_s   = bos[STEPS-1] | flag_r | step_rst;

    // Next state: run beats step in IDLE; leaving RUN/SINGLE only at a boundary.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_next_s = ST_RUN;
                end else if (step) begin
                    state_next_s = ST_SINGLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (boundary_s && !run) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SINGLE: begin
                if (boundary_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SINGLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    jphase_gen #(
        .PHASE_LEN (PHASE_LEN)
    ) u_phase (
        .clk      (clk),
        .rst_n    (rst_n_s),
        .active   (active_s),
        .go       (go_s),
        .wclk     (wclk),
        .wclkd    (wclkd),
        .wclke    (wclke),
        .wclks    (wclks),
        .boundary (boundary_s)
    );

    // FSM state, stepper ring, index, sticky step-reset flag and status outputs.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r    <= ST_IDLE;
            bos        <= BOS_INIT;
            step_idx   <= IDX_W'(0);
            flag_r     <= 1'b0;
            cycle_done <= 1'b0;
            halted     <= 1'b1;
        end else begin
            state_r <= state_next_s;
            halted  <= (state_next_s == ST_IDLE);
            if (boundary_s) begin
                if (wrap_s) begin
                    bos        <= BOS_INIT;
                    step_idx   <= IDX_W'(0);
                    cycle_done <= 1'b1;
                    flag_r     <= 1'b0;
                end else begin
                    bos        <= {1'b0, bos[0:STEPS-2]};
                    step_idx   <= step_idx + IDX_W'(1);
                    cycle_done <= 1'b0;
                    flag_r     <= flag_r;
                end
            end else begin
                cycle_done <= 1'b0;
                flag_r     <= flag_r | step_rst;
            end
        end
    end

endmodule
